// File: rtl/fp_mul_result_stage.sv
// fp_mul_result_stage: two-register post-processing stage behind the
// single-precision multiplier. It resolves specials, over/underflow and flags.
// Ports: clk, reset (sync, active-high)
//        in_valid/in_ready, dataA, dataB, dataR (raw product) -> S1
//        out_valid/out_ready, result, flag_invalid/overflow/underflow <- S2
module fp_mul_result_stage #(
  parameter int          EXP_BIAS  = 127,
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [31:0] dataR,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_overflow,
  output logic        flag_underflow
);

  localparam logic [9:0] BIAS = 10'(EXP_BIAS);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [9:0]  sum;
  } s1_t;

  typedef struct packed {
    logic [31:0] res;
    logic        inv;
    logic        ovf;
    logic        unf;
  } s2_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_vld, s2_vld;
  logic s2_load;

  // S2 takes a new item when empty or being drained this cycle;
  // S1 can refill in the same cycle it hands its item on.
  assign s2_load  = !s2_vld || out_ready;
  assign in_ready = !s1_vld || s2_load;

  always_comb begin
    s1_d.a   = dataA;
    s1_d.b   = dataB;
    s1_d.r   = dataR;
    s1_d.sum = {2'b00, dataA[30:23]}
             + {2'b00, dataB[30:23]}
             - BIAS;
  end

  logic [7:0] ea, eb, carry;
  logic [9:0] e;
  logic       za, zb, ia, ib, na, nb;
  logic       sgn;

  always_comb begin
    ea  = s1_q.a[30:23];
    eb  = s1_q.b[30:23];
    za  = (ea == 8'h00);
    zb  = (eb == 8'h00);
    ia  = (ea == 8'hFF) && (s1_q.a[22:0] == 23'h0);
    ib  = (eb == 8'hFF) && (s1_q.b[22:0] == 23'h0);
    na  = (ea == 8'hFF) && (s1_q.a[22:0] != 23'h0);
    nb  = (eb == 8'hFF) && (s1_q.b[22:0] != 23'h0);
    sgn = s1_q.a[31] ^ s1_q.b[31];
    // The multiplier's exponent already includes its normalisation
    // bump; recover that bump from the low bits of the unbiased sum.
    carry = s1_q.r[30:23] - s1_q.sum[7:0];
    e     = s1_q.sum + {2'b00, carry};
    s2_d  = '0;
    priority case (1'b1)
      na || nb: begin
        s2_d.res = NAN_VALUE;
      end
      (ia && zb) || (za && ib): begin
        s2_d.res = NAN_VALUE;
        s2_d.inv = 1'b1;
      end
      ia || ib: begin
        s2_d.res = {sgn, 8'hFF, 23'h0};
      end
      za || zb: begin
        s2_d.res = {sgn, 31'h0};
      end
      $signed(e) >= 10'sd255: begin
        s2_d.res = {sgn, 8'hFF, 23'h0};
        s2_d.ovf = 1'b1;
      end
      $signed(e) <= 10'sd0: begin
        s2_d.res = {sgn, 31'h0};
        s2_d.unf = 1'b1;
      end
      default: begin
        s2_d.res = s1_q.r;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_vld <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_q <= s2_d;
      end
    end
  end

  // Flag registers keep the last item after a drain; mask them so
  // they only ever describe the result currently on offer.
  assign out_valid      = s2_vld;
  assign result         = s2_q.res;
  assign flag_invalid   = s2_q.inv & s2_vld;
  assign flag_overflow  = s2_q.ovf & s2_vld;
  assign flag_underflow = s2_q.unf & s2_vld;

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// tb_fp_mul_result_stage: directed and random products against a
// rule-level reference model with an in-order scoreboard.
module tb_fp_mul_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready;
  logic [31:0] dataA, dataB, dataR, result;
  logic        flag_invalid, flag_overflow, flag_underflow;

  int          checks   = 0;
  int          failures = 0;
  logic [34:0] exp_q[$];
  logic [34:0] cur_exp;
  logic [34:0] held_d;
  bit          held_v   = 1'b0;
  bit          last_acc = 1'b0;

  always #5 clk = ~clk;

  fp_mul_result_stage dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dataA(dataA),
    .dataB(dataB),
    .dataR(dataR),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flag_invalid(flag_invalid),
    .flag_overflow(flag_overflow),
    .flag_underflow(flag_underflow)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic int carry_of(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [31:0] r);
    int s;
    s = int'(a[30:23]) + int'(b[30:23]) - 127;
    return ((int'(r[30:23]) - s) % 256 + 256) % 256;
  endfunction

  function automatic logic [31:0] mk_r(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input int c,
                                       input logic [22:0] m);
    int s;
    logic [7:0] re;
    s  = int'(a[30:23]) + int'(b[30:23]) - 127;
    re = 8'(s + c);
    return {a[31] ^ b[31], re, m};
  endfunction

  function automatic logic [34:0] model(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] r);
    int   ea, eb, e;
    bit   za, zb, ia, ib, na, nb;
    logic sg;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == '0);
    ib = (eb == 255) && (b[22:0] == '0);
    na = (ea == 255) && (a[22:0] != '0);
    nb = (eb == 255) && (b[22:0] != '0);
    sg = a[31] ^ b[31];
    e  = ea + eb - 127 + carry_of(a, b, r);
    if (na || nb) return {32'h7FC00000, 3'b000};
    if ((ia && zb) || (za && ib)) return {32'h7FC00000, 3'b100};
    if (ia || ib) return {sg, 8'hFF, 23'h0, 3'b000};
    if (za || zb) return {sg, 31'h0, 3'b000};
    if (e >= 255) return {sg, 8'hFF, 23'h0, 3'b010};
    if (e <= 0) return {sg, 31'h0, 3'b001};
    return {r, 3'b000};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: v[30:23] = 8'h00;
      1: begin
        v[30:23] = 8'hFF;
        v[22:0]  = '0;
      end
      2: begin
        v[30:23] = 8'hFF;
        v[0]     = 1'b1;
      end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // One clock: score what the DUT shows, then step to edge+1.
  task automatic cyc();
    logic [34:0] got, want;
    #1;
    got = {result, flag_invalid, flag_overflow, flag_underflow};
    if (held_v) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(got), 64'(held_d));
    end
    if (!out_valid)
      chk("idle_flags", 64'(got[2:0]), 64'd0);
    if (out_valid && out_ready) begin
      chk("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("result", 64'(result), 64'(want[34:3]));
        chk("flags", 64'(got[2:0]), 64'(want[2:0]));
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      chk("carry01", 64'(carry_of(dataA, dataB, dataR) <= 1), 64'd1);
      exp_q.push_back(cur_exp);
    end
    held_v = out_valid && !out_ready;
    held_d = got;
    @(posedge clk);
    #1;
  endtask

  task automatic one(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] r,
                     input logic [34:0] want);
    dataA     = a;
    dataB     = b;
    dataR     = r;
    cur_exp   = want;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk({tag, "_acc"}, 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    cyc();
    chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    cyc();
  endtask

  logic [31:0] a, b, r;
  logic [31:0] bp_r[4];
  int          idx;
  bit          offered;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dataA     = '0;
    dataB     = '0;
    dataR     = '0;
    cur_exp   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({flag_invalid, flag_overflow, flag_underflow}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    one("normal", 32'h40000000, 32'h40400000, 32'h40C00000,
        {32'h40C00000, 3'b000});
    one("ovf_pos", 32'h7F000000, 32'h40000000, 32'h7F800000,
        {32'h7F800000, 3'b010});
    one("ovf_neg", 32'hFF000000, 32'h40000000, 32'hFF800000,
        {32'hFF800000, 3'b010});
    one("unf", 32'h00800000, 32'h00800000, 32'h41800000,
        {32'h00000000, 3'b001});
    a = 32'h7F800000; b = 32'h00000000;
    one("inf_x_zero", a, b, mk_r(a, b, 0, 23'h0),
        {32'h7FC00000, 3'b100});
    a = 32'h7FC00001; b = 32'h3F800000;
    one("nan_in", a, b, mk_r(a, b, 0, 23'h1),
        {32'h7FC00000, 3'b000});
    a = 32'hFF800000; b = 32'h40000000;
    one("neg_inf", a, b, mk_r(a, b, 0, 23'h0),
        {32'hFF800000, 3'b000});
    a = 32'h80000000; b = 32'h3F800000;
    one("neg_zero", a, b, mk_r(a, b, 0, 23'h0),
        {32'h80000000, 3'b000});
    a = 32'h3FC00000; b = 32'h3FC00000;
    one("carry1", a, b, mk_r(a, b, 1, 23'h100000),
        {mk_r(a, b, 1, 23'h100000), 3'b000});

    // Backpressure: four products, consumer stalled for four cycles.
    for (int i = 0; i < 4; i++)
      bp_r[i] = {1'b0, 8'h81, 23'(i * 1000 + 1)};
    idx   = 0;
    dataA = 32'h40000000;
    dataB = 32'h40400000;
    for (int t = 0; t < 14 && (idx < 4 || exp_q.size() != 0); t++) begin
      out_ready = (t >= 4);
      in_valid  = (idx < 4);
      dataR     = (idx < 4) ? bp_r[idx] : 32'h0;
      cur_exp   = {dataR, 3'b000};
      if (t == 2 || t == 3) begin
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_count", 64'(idx), 64'd2);
      end
      cyc();
      if (last_acc) idx++;
    end
    chk("bp_all_in", 64'(idx), 64'd4);
    chk("bp_all_out", 64'(exp_q.size()), 64'd0);
    in_valid = 1'b0;

    // Reset with both stages full.
    out_ready = 1'b0;
    idx       = 0;
    for (int t = 0; t < 6 && idx < 2; t++) begin
      in_valid = 1'b1;
      dataR    = bp_r[idx];
      cur_exp  = {dataR, 3'b000};
      cyc();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("full_count", 64'(idx), 64'd2);
    chk("full_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    held_v = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_flags",
        64'({flag_invalid, flag_overflow, flag_underflow}), 64'd0);
    reset = 1'b0;
    one("post_rst", 32'h40000000, 32'h40400000, 32'h40C00000,
        {32'h40C00000, 3'b000});

    // Random traffic with random stalls on both sides.
    offered = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (!offered && $urandom_range(0, 9) < 7) begin
        a = rnd_op();
        b = rnd_op();
        r = mk_r(a, b, int'($urandom_range(0, 1)), 23'($urandom));
        offered = 1'b1;
      end
      in_valid  = offered;
      dataA     = a;
      dataB     = b;
      dataR     = r;
      cur_exp   = model(a, b, r);
      out_ready = ($urandom_range(0, 9) < 7);
      cyc();
      if (last_acc) offered = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++)
      cyc();
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
